// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch response path, the instruction queue
// and the decoder. The queue connects through the slave modport; the
// producer/consumer side (fetch plus decoder, or a bench) uses master.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_pc_i;
    logic [31:0]     in_data_i;
    logic            in_fault_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    logic [31:0]     out_data_o;
    logic            out_fault_o;

    modport slave (
        input  in_valid_i, in_pc_i, in_data_i, in_fault_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_data_o, out_fault_o
    );

    modport master (
        output in_valid_i, in_pc_i, in_data_i, in_fault_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_data_o, out_fault_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry circular buffer of {pc, data, fault}
// sitting between the fetch response path and the decoder. The oldest entry
// is presented through a valid/ready handshake; flush_i empties the queue in
// one cycle on a redirect. No bypass: a pushed word is visible the cycle
// after it is accepted.

// Occupancy range checker, kept apart from the datapath.
module fetch_queue_chk #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [CW-1:0] count_i
);
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_i <= CW'(DEPTH));
endmodule

module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    fetch_queue_if.slave   bus,
    output logic [CW-1:0]  count_o
);
    // Entry storage; contents are never cleared, only pointers are reset.
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_data_mem  [DEPTH];
    logic            r_fault_mem [DEPTH];

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // Status comes from the registered count only, so in_ready never looks
    // at out_ready: a full queue refuses a push even if it pops this cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});
    assign w_push  = bus.in_valid_i & ~w_full & ~flush_i;
    assign w_pop   = ~w_empty & bus.out_ready_i & ~flush_i;

    // Pointer and occupancy update; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (flush_i) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write the accepted word into the slot at the write pointer.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= bus.in_pc_i;
            r_data_mem[r_wr_ptr]  <= bus.in_data_i;
            r_fault_mem[r_wr_ptr] <= bus.in_fault_i;
        end
    end

    // Head presentation; fields are forced to zero while nothing is valid so
    // the decoder sees an all-zero (invalid) word.
    always_comb begin
        bus.out_valid_o = ~w_empty;
        bus.in_ready_o  = ~w_full;
        bus.out_pc_o    = {XLEN{1'b0}};
        bus.out_data_o  = 32'h0000_0000;
        bus.out_fault_o = 1'b0;
        if (!w_empty) begin
            bus.out_pc_o    = r_pc_mem[r_rd_ptr];
            bus.out_data_o  = r_data_mem[r_rd_ptr];
            bus.out_fault_o = r_fault_mem[r_rd_ptr];
        end else begin
            bus.out_pc_o    = {XLEN{1'b0}};
            bus.out_data_o  = 32'h0000_0000;
            bus.out_fault_o = 1'b0;
        end
    end

    assign count_o = r_count;

    fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .count_i (r_count)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-of-entries reference model is
// updated on each accepted push/flush, and a negedge monitor compares every
// presented head (and the status outputs) against it.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
        logic            fault;
    } ent_t;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          flush_i = 1'b0;
    logic [CW-1:0] count_o;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    int   checks     = 0;
    int   errors     = 0;
    int   delivered  = 0;
    bit   mon_popped = 1'b0;
    ent_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is accepted when the queue held fewer than
    // DEPTH entries at the start of the cycle; flush empties everything.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (flush_i) begin
                exp_q.delete();
            end else if (bus.in_valid_i &&
                         (exp_q.size() + int'(mon_popped)) < DEPTH) begin
                exp_q.push_back('{pc: bus.in_pc_i, data: bus.in_data_i,
                                  fault: bus.in_fault_i});
            end
        end
        mon_popped = 1'b0;
    end

    // Monitor: compare status and head against the model; retire the head
    // when the decoder takes it.
    always @(negedge clk_i) begin
        logic ev;
        ev = (exp_q.size() != 0);
        chk("count", 64'(count_o), 64'(exp_q.size()));
        chk("out_valid", 64'(bus.out_valid_o), 64'(ev));
        chk("in_ready", 64'(bus.in_ready_o), 64'(exp_q.size() < DEPTH));
        if (ev) begin
            chk("out_pc", 64'(bus.out_pc_o), 64'(exp_q[0].pc));
            chk("out_data", 64'(bus.out_data_o), 64'(exp_q[0].data));
            chk("out_fault", 64'(bus.out_fault_o), 64'(exp_q[0].fault));
            if (bus.out_ready_i && !flush_i && rst_ni) begin
                void'(exp_q.pop_front());
                mon_popped = 1'b1;
                delivered++;
            end
        end else begin
            chk("idle_pc", 64'(bus.out_pc_o), 64'h0);
            chk("idle_data", 64'(bus.out_data_o), 64'h0);
            chk("idle_fault", 64'(bus.out_fault_o), 64'h0);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] d,
                       input logic f, input logic r, input logic fl);
        bus.in_valid_i  = v;
        bus.in_pc_i     = pc;
        bus.in_data_i   = d;
        bus.in_fault_i  = f;
        bus.out_ready_i = r;
        flush_i         = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_pop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        bus.in_valid_i  = 1'b0;
        bus.in_pc_i     = 32'h0;
        bus.in_data_i   = 32'h0;
        bus.in_fault_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        #12;
        rst_ni = 1'b1;

        // Two pushes with the decoder stalled: head holds the first word.
        cyc(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        chk("first_visible", 64'(bus.out_valid_o), 64'h1);
        cyc(1'b1, 32'h8000_0004, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
        chk("two_count", 64'(count_o), 64'h2);
        chk("two_head_pc", 64'(bus.out_pc_o), 64'h8000_0000);
        chk("two_head_data", 64'(bus.out_data_o), 64'h0000_0013);
        idle_pop(2);

        // Fill to DEPTH, try a fifth, then pop one.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 32'h8000_0010 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(count_o), 64'(DEPTH));
        chk("full_ready", 64'(bus.in_ready_o), 64'h0);
        cyc(1'b1, 32'h8000_0050, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        chk("fifth_dropped", 64'(count_o), 64'(DEPTH));
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("after_pop_count", 64'(count_o), 64'(DEPTH - 1));
        chk("after_pop_ready", 64'(bus.in_ready_o), 64'h1);
        idle_pop(DEPTH);

        // Streaming push+pop across two pointer wraps.
        cyc(1'b1, 32'h8000_0200, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 32'h8000_0200 + 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0);
            chk("stream_count", 64'(count_o), 64'h1);
        end
        idle_pop(2);

        // Flush with a same-cycle push and pop.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h8000_00c0 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h8000_0100, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
        chk("flush_count", 64'(count_o), 64'h0);
        chk("flush_valid", 64'(bus.out_valid_o), 64'h0);
        chk("flush_ready", 64'(bus.in_ready_o), 64'h1);
        cyc(1'b1, 32'h8000_0300, 32'h0010_0073, 1'b0, 1'b0, 1'b0);
        chk("post_flush_pc", 64'(bus.out_pc_o), 64'h8000_0300);
        idle_pop(2);

        // Faulting word surrounded by clean neighbours.
        cyc(1'b1, 32'h8000_0ffc, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h8000_1000, 32'hdead_beef, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h8000_1004, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
        chk("fault_flag", 64'(bus.out_fault_o), 64'h1);
        chk("fault_data", 64'(bus.out_data_o), 64'hdead_beef);
        idle_pop(3);

        // Asynchronous reset mid-stream with three entries held.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h8000_0400 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        bus.in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_valid", 64'(bus.out_valid_o), 64'h0);
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_ready", 64'(bus.in_ready_o), 64'h1);
        chk("rst_pc", 64'(bus.out_pc_o), 64'h0);
        #2;
        rst_ni = 1'b1;
        cyc(1'b1, 32'h8000_0500, 32'h0000_0093, 1'b0, 1'b0, 1'b0);
        chk("post_rst_push", 64'(bus.out_valid_o), 64'h1);
        idle_pop(2);

        // Randomized traffic; unaccepted words are held stable.
        pc = 32'h8000_2000;
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.in_valid_i && !bus.in_ready_o && !flush_i) begin
                cyc(1'b1, bus.in_pc_i, bus.in_data_i, bus.in_fault_i,
                    1'(($urandom % 3) != 0), 1'(($urandom % 25) == 0));
            end else begin
                pc = pc + 32'h4;
                cyc(1'(($urandom % 4) != 0), pc, $urandom, 1'(($urandom % 8) == 0),
                    1'(($urandom % 3) != 0), 1'(($urandom % 25) == 0));
            end
        end
        idle_pop(DEPTH + 2);
        chk("final_empty", 64'(count_o), 64'h0);
        chk("some_delivered", 64'(delivered > 50), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the instruction-fetch response path and the static decoder. It holds up to DEPTH fetched 32-bit instruction words, each with its PC and a fetch-fault flag. It presents the oldest entry to the decoder through a valid/ready handshake. A single-cycle flush discards all buffered entries on redirect (branch mispredict, exception, fence.i).

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥ 2.
- CW, $clog2(DEPTH+1): width of the occupancy count (derived; not overridden).

Ports:
- clk_i  in  1  clock. Single clock domain; all state updates on the rising edge.
- rst_ni  in  1  reset. Asynchronous, active-low.
- flush_i  in  1  discard all entries and any push presented in the same cycle.
- in_valid_i  in  1  fetch presents a word.
- in_ready_o  out  1  queue accepts a word; equals !full.
- in_pc_i  in  C::XLEN  PC of the presented word.
- in_data_i  in  32  raw instruction word.
- in_fault_i  in  1  fetch access/page fault on this word.
- out_valid_o  out  1  head entry valid toward the decoder.
- out_ready_i  in  1  decoder consumes the head entry.
- out_pc_o  out  C::XLEN  head PC; drives the decoder's pc_i.
- out_data_o  out  32  head word; drives the decoder's data_i.
- out_fault_o  out  1  head fault flag.
- count_o  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries {pc, data, fault}.
- Pointers and count:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally (DEPTH−1 → 0).
  - count is CW bits.
- Handshakes:
  - push = in_valid_i & in_ready_o & !flush_i.
  - pop = out_valid_o & out_ready_i & !flush_i.
- Update rules:
  - push only: write the entry at wr_ptr; wr_ptr+1; count+1.
  - pop only: rd_ptr+1; count−1.
  - push and pop in the same cycle (legal only when not full): both pointers advance; count unchanged.
  - flush_i=1: wr_ptr=rd_ptr=0, count=0. The same-cycle push and pop are ignored. Entry contents are not cleared.
- Status outputs:
  - full = (count == DEPTH); empty = (count == 0).
  - in_ready_o = !full. It is derived from registered state only and does not depend on out_ready_i, so a full queue never accepts a push, even with a same-cycle pop.
  - out_valid_o = !empty.
- Output masking: when out_valid_o=0, out_pc_o, out_data_o and out_fault_o are driven to 0. The decoder therefore sees data 0, which it decodes as invalid.
- Fault entries are queued and delivered like normal entries. The data is passed through unchanged; the decoder and later stages act on out_fault_o.
- Handshake contract:
  - Upstream holds in_* stable while in_valid_i & !in_ready_o.
  - The queue holds out_* stable while out_valid_o & !out_ready_i.
  - With no flush, out_valid_o never drops without a pop.
- A pop when empty and a push when full are impossible by construction. An assertion checks that count stays within 0..DEPTH.

## Timing
- Reset (rst_ni low, asynchronous):
  - pointers = 0, count = 0.
  - in_ready_o=1, out_valid_o=0, out_pc_o=0, out_data_o=0, out_fault_o=0, count_o=0.
  - Leaving reset needs no extra cycle: a push is accepted on the first edge with rst_ni=1.
  - Reset mid-operation drops all entries immediately.
- Latency: no bypass. A word pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. Minimum fetch→decoder latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle in steady state.
- Occupancy:
  - count_o reflects the registered count.
  - in_ready_o deasserts in the cycle after the push that fills the queue.
  - It reasserts in the cycle after the first pop from full.
- Flush:
  - Effective at the next edge: out_valid_o=0 and in_ready_o=1 in the cycle after flush_i.
  - The first post-flush push is accepted in the cycle after flush_i.
  - flush_i held for several cycles keeps the queue empty and drops all pushes.
- Wrap-around: behaviour is identical across the pointer wrap; ordering is preserved.

## Test plan
- Reset with rst_ni asserted mid-stream while count=3 → all outputs go to their reset values asynchronously (out_valid_o=0, count_o=0, in_ready_o=1).
- Push PC 0x80000000/data 0x00000013, then 0x80000004/0x00500093, with out_ready_i=0 → out_valid_o=1 from cycle 1, and out holds 0x80000000/0x00000013 until popped; count_o=2.
- Fill with DEPTH=4 pushes and no pops → in_ready_o=0 after the 4th push. A 5th in_valid_i is not accepted. Popping one raises in_ready_o next cycle; count_o goes 4→3.
- Continuous push plus pop for 10 words (PC step 4) → output PCs appear in order with no gaps, count_o is constant at 1, and the pointers wrap twice.
- With 3 entries queued, assert flush_i alongside in_valid_i (PC 0x80000100) and out_ready_i=1 → next cycle count_o=0 and out_valid_o=0, and PC 0x80000100 is never delivered. A push the following cycle appears at the output one cycle later.
- Push with in_fault_i=1 at PC 0x80001000 → delivered in order with out_fault_o=1 and data unchanged, while neighbouring entries show out_fault_o=0.
